// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: command bytes, FSM state encoding and command decode for the UART system controller
package sys_ctrl_pkg;
  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_BRD     = 8'hBC;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, BRD_ADDR, BRD_LEN, RD_WAIT, RD_SEND,
    RD_ISSUE, OP_A, OP_B, ALU_FUNC, ALU_WAIT, ALU_SEND, ERR_SEND
  } state_e;
  function automatic state_e decode_cmd(input logic [7:0] b);
    return b == CMD_WR      ? WR_ADDR  :
           b == CMD_RD      ? RD_ADDR  :
           b == CMD_BRD     ? BRD_ADDR :
           b == CMD_ALU_OP  ? OP_A     :
           b == CMD_ALU_NOP ? ALU_FUNC : ERR_SEND;
  endfunction
endpackage

// File: rtl/sys_ctrl_timeout.sv
// sys_ctrl_timeout: wait-state counter that flags expiry on the TIMEOUT-th cycle of a wait
module sys_ctrl_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] timer;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) timer <= '0;
    else timer <= clr ? '0 : en ? timer + W'(1) : timer;
  assign expire = en && timer == W'(TIMEOUT - 1);
endmodule

// File: rtl/sys_ctrl_burst.sv
// sys_ctrl_burst: UART command decoder driving RF, ALU and TX FIFO with burst reads and back-pressure
module sys_ctrl_burst
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int OPA_ADDR = 0,
  parameter int OPB_ADDR = 1,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_BYTE = 8'hFF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_Data,
  input  logic                     RX_D_VLD,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     Out_Valid,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic                     FIFO_Full,
  output logic [3:0]               ALU_FUN,
  output logic                     ALU_EN,
  output logic                     CLK_EN,
  output logic [ADDR-1:0]          Address,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     clk_div_en,
  output logic                     Err_Pulse
);
  localparam int NB = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  state_e state;
  logic [ADDR-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] cnt_reg, tx_buf;
  logic [NB-1:0][DATA_WIDTH-1:0] res_reg;
  logic [IW-1:0] byte_idx;
  logic waiting, expire, accept;
  assign waiting = state == RD_WAIT || state == ALU_WAIT;
  assign accept = !FIFO_Full;
  assign clk_div_en = 1'b1;
  sys_ctrl_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .CLK(CLK), .RST(RST), .clr(!waiting), .en(waiting), .expire(expire)
  );
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      addr_reg <= '0;
      cnt_reg <= '0;
      tx_buf <= '0;
      res_reg <= '0;
      byte_idx <= '0;
    end else
      case (state)
        IDLE:     if (RX_D_VLD) state <= decode_cmd(RX_P_Data[7:0]);
        WR_ADDR:  if (RX_D_VLD) begin
                    addr_reg <= RX_P_Data[ADDR-1:0];
                    state <= WR_DATA;
                  end
        WR_DATA:  if (RX_D_VLD) state <= IDLE;
        RD_ADDR:  if (RX_D_VLD) begin
                    addr_reg <= RX_P_Data[ADDR-1:0];
                    cnt_reg <= '0;
                    state <= RD_WAIT;
                  end
        BRD_ADDR: if (RX_D_VLD) begin
                    addr_reg <= RX_P_Data[ADDR-1:0];
                    state <= BRD_LEN;
                  end
        BRD_LEN:  if (RX_D_VLD) begin
                    cnt_reg <= RX_P_Data == '0 ? '0 : RX_P_Data - DATA_WIDTH'(1);
                    state <= RD_WAIT;
                  end
        RD_WAIT:  if (RdData_Valid) begin
                    tx_buf <= RdData;
                    state <= RD_SEND;
                  end else if (expire) state <= ERR_SEND;
        RD_SEND:  if (accept) begin
                    if (cnt_reg == '0) state <= IDLE;
                    else begin
                      cnt_reg <= cnt_reg - DATA_WIDTH'(1);
                      addr_reg <= addr_reg + ADDR'(1);
                      state <= RD_ISSUE;
                    end
                  end
        RD_ISSUE: state <= RD_WAIT;
        OP_A:     if (RX_D_VLD) state <= OP_B;
        OP_B:     if (RX_D_VLD) state <= ALU_FUNC;
        ALU_FUNC: if (RX_D_VLD) state <= ALU_WAIT;
        ALU_WAIT: if (Out_Valid) begin
                    res_reg <= ALU_OUT;
                    byte_idx <= '0;
                    state <= ALU_SEND;
                  end else if (expire) state <= ERR_SEND;
        ALU_SEND: if (accept) begin
                    byte_idx <= byte_idx + IW'(1);
                    if (byte_idx == IW'(NB - 1)) state <= IDLE;
                  end
        ERR_SEND: if (accept) state <= IDLE;
        default:  state <= IDLE;
      endcase
  // RF/ALU strobes are Mealy on RX_D_VLD so they coincide with the qualifying byte
  always_comb begin
    WrEn = RX_D_VLD && (state == WR_DATA || state == OP_A || state == OP_B);
    RdEn = (RX_D_VLD && (state == RD_ADDR || state == BRD_LEN)) || state == RD_ISSUE;
    ALU_EN = RX_D_VLD && state == ALU_FUNC;
    ALU_FUN = ALU_EN ? RX_P_Data[3:0] : 4'h0;
    CLK_EN = state == ALU_FUNC || state == ALU_WAIT;
    WrData = WrEn ? RX_P_Data : '0;
    Address = !(WrEn || RdEn) ? '0 :
              state == RD_ADDR ? RX_P_Data[ADDR-1:0] :
              state == OP_A    ? ADDR'(OPA_ADDR) :
              state == OP_B    ? ADDR'(OPB_ADDR) : addr_reg;
    TX_D_VLD = accept && (state == RD_SEND || state == ALU_SEND || state == ERR_SEND);
    TX_P_DATA = state == RD_SEND  ? tx_buf :
                state == ALU_SEND ? res_reg[byte_idx] :
                state == ERR_SEND ? ERR_BYTE : '0;
    Err_Pulse = accept && state == ERR_SEND;
  end
endmodule

// File: tb/tb_sys_ctrl_burst.sv
// tb_sys_ctrl_burst: randomized self-checking bench with RF/ALU/FIFO responders and a command-level model
module tb_sys_ctrl_burst;
  localparam int TO = 8;
  logic CLK = 0, RST = 0;
  logic [7:0] RX_P_Data = 0;
  logic RX_D_VLD = 0;
  logic [31:0] ALU_OUT = 0;
  logic Out_Valid = 0;
  logic [7:0] RdData = 0;
  logic RdData_Valid = 0, FIFO_Full = 0;
  logic [3:0] ALU_FUN, Address;
  logic ALU_EN, CLK_EN, WrEn, RdEn, TX_D_VLD, clk_div_en, Err_Pulse;
  logic [7:0] WrData, TX_P_DATA;
  logic [29:0] outs;
  int tests = 0, fails = 0, err_cnt = 0;
  logic [7:0] rf [16] = '{default: 8'h00};
  logic [7:0] mrf [16] = '{default: 8'h00};
  logic [7:0] tx_q [$];
  logic [11:0] wr_q [$];
  logic [3:0] rd_q [$], alu_q [$];
  logic rf_on = 1, bp_rand = 0, full_force = 0;
  logic [31:0] alu_val = 0;

  assign outs = {ALU_FUN, ALU_EN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, Err_Pulse};
  always #5 CLK = ~CLK;

  sys_ctrl_burst #(.ALU_OUT_WIDTH(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
    .ALU_OUT(ALU_OUT), .Out_Valid(Out_Valid), .RdData(RdData), .RdData_Valid(RdData_Valid),
    .FIFO_Full(FIFO_Full), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_EN(CLK_EN),
    .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData), .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD), .clk_div_en(clk_div_en), .Err_Pulse(Err_Pulse)
  );

  // Environment: register file, TX FIFO sink and activity logs
  always @(negedge CLK) if (RST) begin
    if (WrEn) begin
      wr_q.push_back({Address, WrData});
      rf[Address] = WrData;
    end
    if (RdEn) rd_q.push_back(Address);
    if (ALU_EN) alu_q.push_back(ALU_FUN);
    if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
    if (Err_Pulse) err_cnt++;
  end

  initial forever begin
    @(negedge CLK);
    if (RST && RdEn && rf_on) begin
      automatic logic [3:0] a = Address;
      repeat ($urandom_range(1, 3)) @(posedge CLK);
      #1 RdData = rf[a]; RdData_Valid = 1;
      @(posedge CLK);
      #1 RdData_Valid = 0; RdData = 8'($urandom);
    end
  end

  initial forever begin
    @(negedge CLK);
    if (RST && ALU_EN) begin
      repeat ($urandom_range(1, 3)) @(posedge CLK);
      #1 ALU_OUT = alu_val; Out_Valid = 1;
      @(posedge CLK);
      #1 Out_Valid = 0; ALU_OUT = $urandom;
    end
  end

  initial forever begin
    @(posedge CLK);
    #2 FIFO_Full = bp_rand ? ($urandom_range(0, 2) == 0) : full_force;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, want finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic rx(input logic [7:0] b);
    RX_P_Data = b; RX_D_VLD = 1;
    @(posedge CLK);
    #1 RX_D_VLD = 0; RX_P_Data = 8'($urandom);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    rx(8'hAA); rx(a); rx(d);
    mrf[a[3:0]] = d;
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_q.size() < n && k < 300) begin
      @(posedge CLK);
      k++;
    end
    tests++;
    if (tx_q.size() < n) begin
      fails++;
      $display("FAIL wait_tx: got %0d bytes, want %0d", tx_q.size(), n);
    end
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      RX_D_VLD = 1'($urandom); RX_P_Data = 8'($urandom);
      @(negedge CLK);
      tests++;
      if (outs !== 30'h0 || clk_div_en !== 1'b1) begin
        fails++;
        $display("FAIL reset_outputs: got outs=%h div=%b, want 0 1", outs, clk_div_en);
      end
      @(posedge CLK);
      #1;
    end
    RX_D_VLD = 0; RST = 1;
    @(negedge CLK);
    tests++;
    if (outs !== 30'h0 || clk_div_en !== 1'b1) begin
      fails++;
      $display("FAIL idle_outputs: got outs=%h div=%b, want 0 1", outs, clk_div_en);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_write;
    logic [7:0] a, d;
    int wb;
    for (int i = -1; i < 16; i++) begin
      a = i < 0 ? 8'h05 : {4'($urandom), 4'(i)};
      d = i < 0 ? 8'h3C : 8'($urandom);
      wb = wr_q.size();
      rx(8'hAA); rx(a);
      RX_P_Data = d; RX_D_VLD = 1;
      @(negedge CLK);
      tests++;
      if (WrEn !== 1'b1 || Address !== a[3:0] || WrData !== d) begin
        fails++;
        $display("FAIL write_strobe: got WrEn=%b Addr=%h Data=%h, want 1 %h %h", WrEn, Address, WrData, a[3:0], d);
      end
      @(posedge CLK);
      #1 RX_D_VLD = 0;
      @(negedge CLK);
      tests++;
      if (wr_q.size() != wb + 1 || WrEn !== 1'b0) begin
        fails++;
        $display("FAIL write_once: got %0d writes WrEn=%b, want 1 0", wr_q.size() - wb, WrEn);
      end
      @(posedge CLK);
      #1 mrf[a[3:0]] = d;
    end
  endtask

  task automatic test_burst_wrap;
    logic [3:0] ea [3] = '{4'hE, 4'hF, 4'h0};
    logic [7:0] ed [3] = '{8'h11, 8'h22, 8'h33};
    int tb, rb;
    wr(8'h0E, 8'h11); wr(8'h0F, 8'h22); wr(8'h00, 8'h33);
    tb = tx_q.size(); rb = rd_q.size();
    rx(8'hBC); rx(8'h0E); rx(8'h03);
    wait_tx(tb + 3);
    tests++;
    if (rd_q.size() != rb + 3) begin
      fails++;
      $display("FAIL burst_rd_count: got %0d, want 3", rd_q.size() - rb);
    end else for (int i = 0; i < 3; i++) begin
      tests++;
      if (rd_q[rb+i] !== ea[i] || tx_q[tb+i] !== ed[i]) begin
        fails++;
        $display("FAIL burst_wrap[%0d]: got addr=%h tx=%h, want %h %h", i, rd_q[rb+i], tx_q[tb+i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_alu32;
    logic [7:0] ed [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    int tb, wb, ab;
    tb = tx_q.size(); wb = wr_q.size(); ab = alu_q.size();
    alu_val = 32'hA1B2C3D4;
    rx(8'hCC); rx(8'h07); rx(8'h03);
    @(negedge CLK);
    tests++;
    if (CLK_EN !== 1'b1) begin
      fails++;
      $display("FAIL alu_clk_en: got %b, want 1", CLK_EN);
    end
    @(posedge CLK);
    #1 rx(8'h00);
    mrf[0] = 8'h07; mrf[1] = 8'h03;
    wait_tx(tb + 4);
    tests++;
    if (wr_q.size() != wb + 2 || wr_q[wb] !== 12'h007 || wr_q[wb+1] !== 12'h103) begin
      fails++;
      $display("FAIL alu_operands: got %0d writes first=%h, want 2 writes 007 103", wr_q.size() - wb, wr_q[wb]);
    end
    tests++;
    if (alu_q.size() != ab + 1 || alu_q[ab] !== 4'h0) begin
      fails++;
      $display("FAIL alu_fun: got %0d strobes, want 1 with fun 0", alu_q.size() - ab);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (tx_q[tb+i] !== ed[i]) begin
        fails++;
        $display("FAIL alu_tx[%0d]: got %h, want %h", i, tx_q[tb+i], ed[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int tb;
    logic [3:0] f;
    tb = tx_q.size();
    alu_val = $urandom; f = 4'($urandom);
    full_force = 1;
    rx(8'hDD); rx({4'h0, f});
    repeat (6) @(posedge CLK);
    #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      tests++;
      if (TX_D_VLD !== 1'b0 || TX_P_DATA !== alu_val[7:0]) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got vld=%b data=%h, want 0 %h", i, TX_D_VLD, TX_P_DATA, alu_val[7:0]);
      end
      @(posedge CLK);
      #1;
    end
    full_force = 0;
    wait_tx(tb + 4);
    tests++;
    if (tx_q.size() != tb + 4) begin
      fails++;
      $display("FAIL bp_count: got %0d, want 4", tx_q.size() - tb);
    end else for (int i = 0; i < 4; i++) begin
      tests++;
      if (tx_q[tb+i] !== alu_val[i*8 +: 8]) begin
        fails++;
        $display("FAIL bp_tx[%0d]: got %h, want %h", i, tx_q[tb+i], alu_val[i*8 +: 8]);
      end
    end
  endtask

  task automatic test_timeout_error;
    int n = 0, eb, wb, tb;
    logic got = 0;
    eb = err_cnt; wb = wr_q.size();
    rf_on = 0;
    rx(8'hBB); rx(8'h02);
    while (!got && n < 20) begin
      n++;
      RX_D_VLD = n == 3; RX_P_Data = 8'hAA;
      @(negedge CLK);
      if (TX_D_VLD) begin
        got = 1;
        tests++;
        if (n != TO + 1 || TX_P_DATA !== 8'hFF || Err_Pulse !== 1'b1) begin
          fails++;
          $display("FAIL timeout_err: got cycle=%0d data=%h pulse=%b, want %0d FF 1", n, TX_P_DATA, Err_Pulse, TO + 1);
        end
      end
      @(posedge CLK);
      #1;
    end
    RX_D_VLD = 0;
    rf_on = 1;
    tests++;
    if (!got || err_cnt != eb + 1 || wr_q.size() != wb) begin
      fails++;
      $display("FAIL timeout_seen: got seen=%b errs=%0d writes=%0d, want 1 1 0", got, err_cnt - eb, wr_q.size() - wb);
    end
    tb = tx_q.size();
    full_force = 1;
    rx(8'h57);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      tests++;
      if (TX_D_VLD !== 1'b0 || Err_Pulse !== 1'b0 || TX_P_DATA !== 8'hFF) begin
        fails++;
        $display("FAIL err_stall: got vld=%b pulse=%b data=%h, want 0 0 FF", TX_D_VLD, Err_Pulse, TX_P_DATA);
      end
      @(posedge CLK);
      #1;
    end
    full_force = 0;
    wait_tx(tb + 1);
    tests++;
    if (tx_q.size() != tb + 1 || tx_q[tb] !== 8'hFF || err_cnt != eb + 2) begin
      fails++;
      $display("FAIL bad_cmd: got %0d bytes errs=%0d, want 1 FF byte 2 errs", tx_q.size() - tb, err_cnt - eb);
    end
  endtask

  task automatic test_reset_mid_burst;
    int tb, rb;
    logic [7:0] d;
    full_force = 1;
    rx(8'hBC); rx(8'h03); rx(8'h05);
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    tests++;
    if (TX_P_DATA !== mrf[3] || TX_D_VLD !== 1'b0) begin
      fails++;
      $display("FAIL burst_stall: got data=%h vld=%b, want %h 0", TX_P_DATA, TX_D_VLD, mrf[3]);
    end
    #2 RST = 0;
    #1;
    tests++;
    if (outs !== 30'h0 || clk_div_en !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: got outs=%h div=%b, want 0 1", outs, clk_div_en);
    end
    @(posedge CLK);
    #1 full_force = 0;
    @(posedge CLK);
    #1 RST = 1;
    tb = tx_q.size(); rb = rd_q.size();
    d = 8'($urandom);
    wr(8'h09, d);
    repeat (4) @(posedge CLK);
    #1;
    tests++;
    if (wr_q[wr_q.size()-1] !== {4'h9, d} || tx_q.size() != tb || rd_q.size() != rb) begin
      fails++;
      $display("FAIL post_reset_write: got wr=%h tx+%0d rd+%0d, want %h +0 +0", wr_q[wr_q.size()-1], tx_q.size() - tb, rd_q.size() - rb, {4'h9, d});
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b1, b2, b3, c;
    logic [3:0] a;
    int kind, n, tb, wb, rb, ab, eb, eerr;
    logic [7:0] etx [$];
    logic [11:0] ewr [$];
    logic [3:0] erd [$], ealu [$];
    bp_rand = 1;
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 5);
      b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      tb = tx_q.size(); wb = wr_q.size(); rb = rd_q.size(); ab = alu_q.size(); eb = err_cnt;
      etx.delete(); ewr.delete(); erd.delete(); ealu.delete(); eerr = 0;
      case (kind)
        0: begin
          rx(8'hAA); rx(b1); rx(b2);
          ewr.push_back({b1[3:0], b2}); mrf[b1[3:0]] = b2;
        end
        1: begin
          rx(8'hBB); rx(b1);
          erd.push_back(b1[3:0]); etx.push_back(mrf[b1[3:0]]);
        end
        2: begin
          b2 = 8'(b2 % 5);
          n = b2 == 0 ? 1 : int'(b2);
          rx(8'hBC); rx(b1); rx(b2);
          for (int i = 0; i < n; i++) begin
            a = b1[3:0] + 4'(i);
            erd.push_back(a); etx.push_back(mrf[a]);
          end
        end
        3, 4: begin
          alu_val = $urandom;
          if (kind == 3) begin
            rx(8'hCC); rx(b1); rx(b2);
            ewr.push_back({4'h0, b1}); ewr.push_back({4'h1, b2});
            mrf[0] = b1; mrf[1] = b2;
          end else rx(8'hDD);
          rx(b3);
          ealu.push_back(b3[3:0]);
          for (int i = 0; i < 4; i++) etx.push_back(alu_val[i*8 +: 8]);
        end
        default: begin
          c = 8'($urandom);
          while (c == 8'hAA || c == 8'hBB || c == 8'hBC || c == 8'hCC || c == 8'hDD) c = 8'($urandom);
          rx(c);
          etx.push_back(8'hFF); eerr = 1;
        end
      endcase
      wait_tx(tb + etx.size());
      tests++;
      if (tx_q.size() - tb != etx.size()) begin
        fails++;
        $display("FAIL b2b_tx_count it=%0d kind=%0d: got %0d, want %0d", it, kind, tx_q.size() - tb, etx.size());
      end else for (int i = 0; i < etx.size(); i++) begin
        tests++;
        if (tx_q[tb+i] !== etx[i]) begin
          fails++;
          $display("FAIL b2b_tx it=%0d kind=%0d [%0d]: got %h, want %h", it, kind, i, tx_q[tb+i], etx[i]);
        end
      end
      tests++;
      if (wr_q.size() - wb != ewr.size() || rd_q.size() - rb != erd.size() || alu_q.size() - ab != ealu.size() || err_cnt - eb != eerr) begin
        fails++;
        $display("FAIL b2b_counts it=%0d kind=%0d: got wr=%0d rd=%0d alu=%0d err=%0d, want %0d %0d %0d %0d", it, kind,
                 wr_q.size() - wb, rd_q.size() - rb, alu_q.size() - ab, err_cnt - eb, ewr.size(), erd.size(), ealu.size(), eerr);
      end else begin
        for (int i = 0; i < ewr.size(); i++) begin
          tests++;
          if (wr_q[wb+i] !== ewr[i]) begin
            fails++;
            $display("FAIL b2b_wr it=%0d [%0d]: got %h, want %h", it, i, wr_q[wb+i], ewr[i]);
          end
        end
        for (int i = 0; i < erd.size(); i++) begin
          tests++;
          if (rd_q[rb+i] !== erd[i]) begin
            fails++;
            $display("FAIL b2b_rd it=%0d [%0d]: got %h, want %h", it, i, rd_q[rb+i], erd[i]);
          end
        end
        for (int i = 0; i < ealu.size(); i++) begin
          tests++;
          if (alu_q[ab+i] !== ealu[i]) begin
            fails++;
            $display("FAIL b2b_alu it=%0d: got %h, want %h", it, alu_q[ab+i], ealu[i]);
          end
        end
      end
    end
    bp_rand = 0;
  endtask

  initial begin
    test_reset;
    test_write;
    test_burst_wrap;
    test_alu32;
    test_backpressure;
    test_timeout_error;
    test_reset_mid_burst;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
